// File: rtl/projectmux_uart_tx.sv
// UART transmitter for the Projectmux datapath: one byte per valid/ready handshake, 8N1 frame.
// Define PROJECTMUX_UART_PARITY_EN to insert an even-parity bit after data bit 7 (11-bit frame).
module projectmux_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef PROJECTMUX_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_n;
    logic [BW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, shreg_n;
    logic            tx_n;
    logic            bit_end;

`ifdef PROJECTMUX_UART_PARITY_EN
    logic            par, par_n;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef PROJECTMUX_UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
`ifdef PROJECTMUX_UART_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    // tx is registered from the next-state decode, so each level appears on the edge its bit starts
    always_comb begin
        state_n = state;
        tx_n    = tx;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
`ifdef PROJECTMUX_UART_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE)
            baud_n = bit_end ? '0 : baud_cnt + 1'b1;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (in_valid) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    shreg_n = in_data;
                    baud_n  = '0;
                    bit_n   = '0;
`ifdef PROJECTMUX_UART_PARITY_EN
                    par_n   = ^in_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == 3'd7) begin
`ifdef PROJECTMUX_UART_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        tx_n  = shreg[1];
                    end
                end
            end
`ifdef PROJECTMUX_UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_projectmux_uart_tx.sv
// Bench for projectmux_uart_tx: C=4 and C=2 instances against a frame-level model plus literal frames.
module tb_projectmux_uart_tx;

`ifdef PROJECTMUX_UART_PARITY_EN
    localparam int LEN = 11;
`else
    localparam int LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v[2];
    logic [7:0] d[2];
    logic       txo[2], rdy[2], bsy[2];

    int checks = 0;
    int errors = 0;

    projectmux_uart_tx #(.CLKS_PER_BIT(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy[0]),
        .in_data(d[0]), .tx(txo[0]), .busy(bsy[0]));
    projectmux_uart_tx #(.CLKS_PER_BIT(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy[1]),
        .in_data(d[1]), .tx(txo[1]), .busy(bsy[1]));

    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // frame as a bit list: [0]=start, [1..8]=data LSB first, then parity, then stop
    function automatic logic [10:0] frame(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int n = 0; n < 8; n++) f[1+n] = b[n];
`ifdef PROJECTMUX_UART_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // model: is a frame running, how many cycles since its accept edge, and its bits
    bit          m_act[2] = '{0, 0};
    int          m_t[2]   = '{0, 0};
    logic [10:0] m_fr[2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_t[i] + 1 == LEN * cpb(i)) m_act[i] <= 1'b0;
                m_t[i] <= m_t[i] + 1;
            end else if (v[i]) begin
                m_act[i] <= 1'b1;
                m_t[i]   <= 0;
                m_fr[i]  <= frame(d[i]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic etx;
            etx = m_act[i] ? m_fr[i][m_t[i] / cpb(i)] : 1'b1;
            chk($sformatf("model_tx%0d", i), txo[i], etx);
            chk($sformatf("model_ready%0d", i), rdy[i], !m_act[i]);
            chk($sformatf("model_busy%0d", i), bsy[i], m_act[i]);
        end
    end

    logic cap_tx[128], cap_rdy[128], cap_bsy[128];

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", i), rdy[i], 1'b1);
    endtask

    // raise valid at a negedge; the following posedge is the accept edge
    task automatic send(input int i, input logic [7:0] b);
        wait_idle(i);
        @(negedge clk);
        v[i] = 1'b1;
        d[i] = b;
        @(posedge clk);
    endtask

    // cap[t] is sampled in the cycle following edge k+t (k = accept edge)
    task automatic capture(input int i, input int n, input bit drop);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            cap_tx[t]  = txo[i];
            cap_rdy[t] = rdy[i];
            cap_bsy[t] = bsy[i];
            if (t == 0 && drop) v[i] = 1'b0;
        end
    endtask

    task automatic chk_frame(input string nm, input int c, input int nb, input logic [10:0] bits);
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("%s_bit%0d_first", nm, b), cap_tx[b*c], bits[b]);
            chk($sformatf("%s_bit%0d_last", nm, b), cap_tx[b*c+c-1], bits[b]);
        end
    endtask

    function automatic int count_low_ready(input int n);
        int k;
        k = 0;
        for (int t = 0; t < n; t++) if (cap_rdy[t] === 1'b0) k++;
        return k;
    endfunction

    initial begin
        int sec, ones;
        v[0] = 0; v[1] = 0; d[0] = 0; d[1] = 0;

        // reset held three cycles, then idle line
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_tx", txo[0], 1'b1);
            chk("rst_ready", rdy[0], 1'b1);
            chk("rst_busy", bsy[0], 1'b0);
        end
        rst = 1'b0;
        capture(0, 10, 0);
        for (int t = 0; t < 10; t++) chk("idle_tx", cap_tx[t], 1'b1);

`ifdef PROJECTMUX_UART_PARITY_EN
        send(0, 8'h07);
        capture(0, 60, 1);
        chk_frame("p07", 4, 11, 11'b11000001110);
        chk("p07_busy_cycles", count_low_ready(60), 44);
        send(0, 8'hA5);
        capture(0, 60, 1);
        chk_frame("pA5", 4, 11, 11'b10101001010);
        chk("pA5_parity", cap_tx[9*4+2], 1'b0);
`else
        send(0, 8'hA5);
        capture(0, 60, 1);
        chk_frame("A5", 4, 10, 10'b1101001010);
        chk("A5_ready_low", count_low_ready(60), 40);
        chk("A5_ready_back", cap_rdy[40], 1'b1);
`endif

        // back-to-back with valid held; data changes while busy must not leak into frames
        wait_idle(0);
        @(negedge clk);
        v[0] = 1'b1;
        d[0] = 8'h00;
        @(posedge clk);
        for (int t = 0; t < 110; t++) begin
            @(negedge clk);
            cap_tx[t]  = txo[0];
            cap_rdy[t] = rdy[0];
            if (t == 0) d[0] = 8'hFF;
            if (t == LEN*4 + 1) begin
                v[0] = 1'b0;
                d[0] = 8'h00;
            end
        end
        sec = -1;
        for (int t = LEN*4 - 4; t < 110; t++)
            if (sec < 0 && cap_tx[t] == 1'b0 && cap_tx[t-1] == 1'b1) sec = t;
        ones = 0;
        for (int t = sec - 1; t > 0 && cap_tx[t] == 1'b1; t--) ones++;
        chk("b2b_start_gap", sec, LEN*4 + 1);
        chk("b2b_idle_ones", ones, 4 + 1);
        for (int n = 0; n < 8; n++) chk("b2b_first_data", cap_tx[4*(1+n)+1], 1'b0);
        for (int n = 0; n < 8; n++) chk("b2b_second_data", cap_tx[sec + 4*(1+n) + 2], 1'b1);

        // asynchronous reset during data bit 3 of 0x55 (offsets 16..19)
        send(0, 8'h55);
        capture(0, 18, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", txo[0], 1'b1);
        chk("async_rst_ready", rdy[0], 1'b1);
        chk("async_rst_busy", bsy[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h3C);
        capture(0, 60, 1);
`ifdef PROJECTMUX_UART_PARITY_EN
        chk_frame("3C", 4, 11, 11'b10001111000);
`else
        chk_frame("3C", 4, 10, 10'b1001111000);
`endif

        // minimum divider: bit 7 of 0x80 at offsets 16..17
        send(1, 8'h80);
        capture(1, 40, 1);
        chk("c2_bit6", cap_tx[15], 1'b0);
        chk("c2_bit7a", cap_tx[16], 1'b1);
        chk("c2_bit7b", cap_tx[17], 1'b1);
        chk("c2_start", cap_tx[1], 1'b0);
        chk("c2_frame_len", count_low_ready(40), LEN*2);

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: bench did not complete", $time);
        $fatal(1);
    end

endmodule
